// File: rtl/xmpl_dsp_cic.sv
// xmpl_dsp_cic: N-stage CIC decimator (ratio 2**R_LOG2) with frame-based run control.
// Integrators run at the input rate. The comb chain runs on every R-th accepted sample.
// A run first fills the filter, then delivers FRAME_LEN samples and parks in DONE.
module xmpl_dsp_cic #(
  parameter int IW        = 14,
  parameter int N         = 3,
  parameter int R_LOG2    = 3,
  parameter int FRAME_LEN = 16,
  localparam int OW       = IW + N * R_LOG2
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 en_xmpl_dsp_cic_i,
  input  logic signed [IW-1:0] cic_din_i,
  input  logic                 cic_din_vld_i,
  output logic signed [OW-1:0] cic_dout_o,
  output logic                 cic_dout_vld_o,
  output logic                 xmpl_dsp_cic_status_o,
  output logic [1:0]           cic_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int              FW         = $clog2(FRAME_LEN + 1);
  localparam logic [2:0]      FILL_LAST  = 3'(N - 1);
  localparam logic [FW-1:0]   FRAME_LAST = FW'(FRAME_LEN - 1);

  state_t                state_q, state_d;
  logic [R_LOG2-1:0]     dec_cnt_q, dec_cnt_d;
  logic [2:0]            fill_cnt_q, fill_cnt_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic signed [OW-1:0]  integ_q [N];
  logic signed [OW-1:0]  integ_d [N];
  logic signed [OW-1:0]  dly_q [N];
  logic signed [OW-1:0]  dly_d [N];
  logic signed [OW-1:0]  v_sum [N];
  logic signed [OW-1:0]  c_sum [N];
  logic signed [OW-1:0]  sum_acc, dif_acc;
  logic signed [OW-1:0]  dout_q, dout_d;
  logic                  dout_vld_q, dout_vld_d;
  logic                  clear, accept, strobe, fill_done, frame_done;

  // Sign-extend an input sample to the full-precision accumulator width.
  function automatic logic signed [OW-1:0] sext_in(input logic signed [IW-1:0] x);
    return OW'(x);
  endfunction

  // Dropping enable or sitting in IDLE holds the whole datapath at zero.
  assign clear      = !en_xmpl_dsp_cic_i || (state_q == IDLE);
  assign accept     = cic_din_vld_i && ((state_q == FILL) || (state_q == RUN));
  assign strobe     = accept && (&dec_cnt_q);
  // The N-th decimated output completes the fill and is the first one delivered.
  assign fill_done  = strobe && (state_q == FILL) && (fill_cnt_q == FILL_LAST);
  assign frame_done = strobe && (state_q == RUN) && (frame_cnt_q == FRAME_LAST);

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // FSM next-state: enable low always returns to IDLE, aborting any frame.
  always_comb begin
    state_d = state_q;
    if (!en_xmpl_dsp_cic_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = FILL;
        FILL:    if (fill_done) state_d = (FRAME_LEN == 1) ? DONE : RUN;
        RUN:     if (frame_done) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: output-valid pulse plus the fill and frame counters.
  always_comb begin
    fill_cnt_d  = fill_cnt_q;
    frame_cnt_d = frame_cnt_q;
    dout_vld_d  = 1'b0;
    if (clear) begin
      fill_cnt_d  = '0;
      frame_cnt_d = '0;
    end else if (fill_done) begin
      dout_vld_d  = 1'b1;
      frame_cnt_d = FW'(1);
    end else if (strobe && (state_q == FILL)) begin
      fill_cnt_d  = fill_cnt_q + 3'd1;
    end else if (strobe && (state_q == RUN)) begin
      dout_vld_d  = 1'b1;
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  // Integrator running sums and comb differences for the sample at the input.
  always_comb begin
    sum_acc = sext_in(cic_din_i);
    for (int k = 0; k < N; k++) begin
      sum_acc  = integ_q[k] + sum_acc;
      v_sum[k] = sum_acc;
    end
    dif_acc = sum_acc;
    for (int k = 0; k < N; k++) begin
      c_sum[k] = dif_acc - dly_q[k];
      dif_acc  = c_sum[k];
    end
  end

  // Datapath next-state: integrate on every accepted sample, comb on the strobe.
  always_comb begin
    integ_d   = integ_q;
    dly_d     = dly_q;
    dec_cnt_d = dec_cnt_q;
    dout_d    = dout_q;
    if (clear) begin
      for (int k = 0; k < N; k++) begin
        integ_d[k] = '0;
        dly_d[k]   = '0;
      end
      dec_cnt_d = '0;
      dout_d    = '0;
    end else if (accept) begin
      integ_d   = v_sum;
      dec_cnt_d = dec_cnt_q + 1'b1;
      if (strobe) begin
        dly_d[0] = v_sum[N-1];
        for (int k = 1; k < N; k++) dly_d[k] = c_sum[k-1];
        dout_d = c_sum[N-1];
      end
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      dec_cnt_q   <= '0;
      fill_cnt_q  <= '0;
      frame_cnt_q <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
    end else begin
      integ_q     <= integ_d;
      dly_q       <= dly_d;
      dec_cnt_q   <= dec_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
    end
  end

  assign cic_dout_o            = dout_q;
  assign cic_dout_vld_o        = dout_vld_q;
  assign xmpl_dsp_cic_status_o = (state_q == DONE);
  assign cic_state_o           = state_q;

endmodule

// File: tb/tb_xmpl_dsp_cic.sv
// tb_xmpl_dsp_cic: directed bench for the CIC decimator with default parameters.
// Frame vectors live in a table; abort and reset corner cases are hand sequences.
module tb_xmpl_dsp_cic;

  localparam int IW        = 14;
  localparam int FRAME_LEN = 16;
  localparam int OW        = 23;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic                 vld = 1'b0;
  logic signed [IW-1:0] din = '0;
  logic signed [OW-1:0] dout;
  logic                 dout_vld;
  logic                 status;
  logic [1:0]           state;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xmpl_dsp_cic dut (
    .clk_i                 (clk),
    .reset_n_i             (rst_n),
    .en_xmpl_dsp_cic_i     (en),
    .cic_din_i             (din),
    .cic_din_vld_i         (vld),
    .cic_dout_o            (dout),
    .cic_dout_vld_o        (dout_vld),
    .xmpl_dsp_cic_status_o (status),
    .cic_state_o           (state)
  );

  // One frame run: first accepted sample x_first, the rest x_rest.
  // Cycle 1 is the cycle in which en and the first (ignored) sample are presented.
  // fill0/fill1 are the two undelivered FILL outputs, seen 2 and 1 spacings before the first pulse.
  typedef struct {
    int x_first;
    int x_rest;
    bit gap;
    int first_cyc;
    int spacing;
    int fill0;
    int fill1;
    int val;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string what, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", what, act, exp);
    end
  endtask

  task automatic run_frame(input int id, input vec_t v);
    int acc;
    int npulse;
    int limit;
    int extra;
    @(negedge clk);
    en  = 1'b1;
    vld = 1'b1;
    din = IW'(v.x_rest);
    acc = 0;
    npulse = 0;
    limit = v.first_cyc + (FRAME_LEN - 1) * v.spacing;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == v.first_cyc - 2 * v.spacing) begin
        chk($sformatf("v%0d fill out 0", id), longint'(dout), v.fill0);
        chk($sformatf("v%0d fill vld 0", id), dout_vld, 0);
      end
      if (c == v.first_cyc - v.spacing) begin
        chk($sformatf("v%0d fill out 1", id), longint'(dout), v.fill1);
        chk($sformatf("v%0d fill vld 1", id), dout_vld, 0);
      end
      if (dout_vld) begin
        chk($sformatf("v%0d pulse %0d cycle", id, npulse), c, v.first_cyc + npulse * v.spacing);
        chk($sformatf("v%0d pulse %0d value", id, npulse), longint'(dout), v.val);
        npulse++;
        chk($sformatf("v%0d pulse %0d state", id, npulse), state, (npulse == FRAME_LEN) ? 3 : 2);
        chk($sformatf("v%0d pulse %0d status", id, npulse), status, (npulse == FRAME_LEN) ? 1 : 0);
      end
      vld = v.gap ? ((c % 2) == 0) : 1'b1;
      din = (acc == 0) ? IW'(v.x_first) : IW'(v.x_rest);
      if (vld) acc++;
    end
    chk($sformatf("v%0d pulse count", id), npulse, FRAME_LEN);
    // DONE: input keeps arriving but nothing moves.
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      vld = 1'b1;
      din = IW'(c * 37 - 300);
      @(negedge clk);
      if (dout_vld) extra++;
    end
    chk($sformatf("v%0d pulses in DONE", id), extra, 0);
    chk($sformatf("v%0d DONE hold value", id), longint'(dout), v.val);
    chk($sformatf("v%0d DONE state", id), state, 3);
    chk($sformatf("v%0d DONE status", id), status, 1);
    en = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d back to IDLE", id), state, 0);
    chk($sformatf("v%0d status cleared", id), status, 0);
    chk($sformatf("v%0d dout cleared", id), longint'(dout), 0);
  endtask

  initial begin
    int npulse;
    int extra;

    vecs[0] = '{x_first: 1,     x_rest: 1,     gap: 1'b0, first_cyc: 25, spacing: 8,
                fill0: 120,     fill1: 456,     val: 512};
    vecs[1] = '{x_first: -1,    x_rest: -1,    gap: 1'b0, first_cyc: 25, spacing: 8,
                fill0: -120,    fill1: -456,    val: -512};
    vecs[2] = '{x_first: 1,     x_rest: 0,     gap: 1'b0, first_cyc: 25, spacing: 8,
                fill0: 36,      fill1: 28,      val: 0};
    vecs[3] = '{x_first: 8191,  x_rest: 8191,  gap: 1'b1, first_cyc: 49, spacing: 16,
                fill0: 982920,  fill1: 3735096, val: 4193792};
    vecs[4] = '{x_first: -8192, x_rest: -8192, gap: 1'b0, first_cyc: 25, spacing: 8,
                fill0: -983040, fill1: -3735552, val: -4194304};

    // Reset held with enable and valid input applied.
    en  = 1'b1;
    vld = 1'b1;
    din = 14'sd5;
    repeat (3) @(negedge clk);
    chk("reset state", state, 0);
    chk("reset dout", longint'(dout), 0);
    chk("reset vld", dout_vld, 0);
    chk("reset status", status, 0);
    en = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle after release", state, 0);

    for (int i = 0; i < 5; i++) run_frame(i, vecs[i]);

    // Enable dropped after five delivered pulses.
    en  = 1'b1;
    vld = 1'b1;
    din = 14'sd1;
    npulse = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (dout_vld) npulse++;
      if (npulse == 5) break;
    end
    chk("abort pulses seen", npulse, 5);
    en = 1'b0;
    @(negedge clk);
    chk("abort state", state, 0);
    chk("abort status", status, 0);
    chk("abort dout", longint'(dout), 0);
    chk("abort vld", dout_vld, 0);
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dout_vld || status) extra++;
    end
    chk("abort quiet", extra, 0);
    chk("abort still idle", state, 0);

    // Fresh run after the abort.
    run_frame(10, vecs[0]);

    // Asynchronous reset in the middle of RUN.
    en  = 1'b1;
    vld = 1'b1;
    din = 14'sd1;
    npulse = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (dout_vld) npulse++;
      if (npulse == 3) break;
    end
    chk("pre-reset pulses", npulse, 3);
    chk("pre-reset state", state, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst state", state, 0);
    chk("async rst dout", longint'(dout), 0);
    chk("async rst vld", dout_vld, 0);
    chk("async rst status", status, 0);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("held in reset", state, 0);
    rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (dout_vld || state != 2'd0) extra++;
    end
    chk("idle until enable", extra, 0);
    run_frame(11, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
